// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared fetch-stage types and defaults.
//   fetch_state_t  fetch sequencer states
//   DEF_XLEN       default datapath/address width
//   DEF_NOP_INSTR  default bubble instruction word
package cpu_pipe_pkg;
    localparam int DEF_XLEN = 32;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush > stall > load > bubble priority.
//   clk_i, rst_i (async, active-low)
//   flush_i  clear all fields
//   stall_i  hold all fields
//   load_i   capture {pc4_i, instr_i} as a valid instruction
//   pc4_o, instr_o, valid_o  register contents
module if_id_reg import cpu_pipe_pkg::*; #(
    parameter int          XLEN      = DEF_XLEN,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] pc4_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);
    logic [XLEN-1:0] pc4_q;
    logic [31:0]     instr_q;
    logic            valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            // A bubble keeps pc4 so ID still sees the last fall-through address.
            pc4_q   <= load_i ? pc4_i : pc4_q;
            instr_q <= load_i ? instr_i : NOP_INSTR;
            valid_q <= load_i;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch sequencer feeding the IF/ID register.
//   clk_i, rst_i (async, active-low)
//   pc_i / pc_write_o        ProgramCounter interface
//   imem_req_o/addr_o/ack_i/data_i  instruction-memory handshake
//   stall_i, flush_i         hazard/redirect controls from later stages
//   ifid_pc4_o/instr_o/valid_o  IF/ID register outputs
//   err_o                    sticky fetch-timeout flag
module if_fetch_ctrl import cpu_pipe_pkg::*; #(
    parameter int          XLEN      = DEF_XLEN,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter int          TIMEOUT   = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_write_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] ifid_pc4_o,
    output logic [31:0]     ifid_instr_o,
    output logic            ifid_valid_o,
    output logic            err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            accept;
    logic            waiting;

    assign accept  = !stall_i && !flush_i && ((state_q == WAIT && imem_ack_i) || state_q == HOLD);
    assign waiting = state_q == WAIT || state_q == DROP;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            // A flush in IDLE reloads the PC this edge, so sample it again next cycle.
            IDLE: if (!flush_i) begin
                addr_d  = pc_i;
                state_d = WAIT;
            end
            WAIT: if (imem_ack_i) begin
                buf_d   = imem_data_i;
                state_d = (stall_i && !flush_i) ? HOLD : IDLE;
            end else if (flush_i) begin
                state_d = DROP;
            end
            HOLD: state_d = (flush_i || !stall_i) ? IDLE : HOLD;
            DROP: state_d = imem_ack_i ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
        // Saturate so a long hang cannot wrap the counter back below TIMEOUT.
        cnt_d = (waiting && !imem_ack_i) ? ((cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1) : '0;
        err_d = err_q || (cnt_d == CW'(TIMEOUT));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pc_write_o  = accept || flush_i;
    assign imem_req_o  = state_q == WAIT;
    assign imem_addr_o = addr_q;
    assign err_o       = err_q;

    if_id_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .stall_i (stall_i),
        .load_i  (accept),
        .pc4_i   (addr_q + XLEN'(4)),
        .instr_i ((state_q == HOLD) ? buf_q : imem_data_i),
        .pc4_o   (ifid_pc4_o),
        .instr_o (ifid_instr_o),
        .valid_o (ifid_valid_o)
    );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed vectors, timeout/reset sequence and random run against a transaction model.
module tb_if_fetch_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] pc_i = '0, imem_addr_o, imem_data_i = '0;
    logic        pc_write_o, imem_req_o, imem_ack_i = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] ifid_pc4_o, ifid_instr_o;
    logic        ifid_valid_o, err_o;

    int total = 0;
    int bad = 0;

    if_fetch_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .pc_write_o   (pc_write_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_valid_o (ifid_valid_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic [31:0] data;
        logic        stall;
        logic        flush;
        logic        req;
        logic [31:0] addr;
        logic        pcw;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    vec_t tv[$];

    // Transaction-level reference: an outstanding request (possibly squashed),
    // an optional parked word, and a count of consecutive unanswered cycles.
    logic        m_out, m_drop, m_have, m_err, m_v;
    logic [31:0] m_addr, m_word, m_pc4, m_instr;
    int          m_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] data,
                         input logic stall, input logic flush);
        pc_i = pc;
        imem_ack_i = ack;
        imem_data_i = data;
        stall_i = stall;
        flush_i = flush;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic model_step(input logic [31:0] pc, input logic ack, input logic [31:0] data,
                              input logic stall, input logic flush);
        logic acc;
        acc = !stall && !flush && ((m_out && !m_drop && ack) || m_have);
        if (flush) begin
            m_v = 0; m_instr = 0; m_pc4 = 0;
        end else if (!stall) begin
            if (acc) begin
                m_pc4 = m_addr + 32'd4; m_instr = m_have ? m_word : data; m_v = 1;
            end else begin
                m_v = 0; m_instr = 0;
            end
        end
        if (m_out && !ack) begin
            m_miss++;
            if (m_miss >= 16) m_err = 1;
        end else m_miss = 0;
        if (m_have) begin
            if (flush || !stall) m_have = 0;
        end else if (m_out) begin
            if (ack) begin
                m_out = 0;
                if (!m_drop && stall && !flush) begin m_have = 1; m_word = data; end
                m_drop = 0;
            end else if (flush) m_drop = 1;
        end else if (!flush) begin
            m_out = 1; m_drop = 0; m_addr = pc;
        end
    endtask

    initial begin
        //            pc            ack data          stl flu req addr          pcw pc4           instr         v
        tv.push_back(vec_t'{32'h100, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h100, 1, 32'h8C010004, 0, 0, 1, 32'h100,      1, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h104, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h104,      32'h8C010004, 1});
        tv.push_back(vec_t'{32'h104, 1, 32'h20420001, 1, 0, 1, 32'h104,      0, 32'h104,      32'h0,        0});
        tv.push_back(vec_t'{32'h104, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h104,      32'h0,        0});
        tv.push_back(vec_t'{32'h104, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h104,      32'h0,        0});
        tv.push_back(vec_t'{32'h104, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h104,      32'h0,        0});
        tv.push_back(vec_t'{32'h108, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h108,      32'h20420001, 1});
        tv.push_back(vec_t'{32'h108, 0, 32'h0,        0, 1, 1, 32'h108,      1, 32'h108,      32'h0,        0});
        tv.push_back(vec_t'{32'h400, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h400, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h400, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h400, 1, 32'h11111111, 0, 0, 1, 32'h400,      1, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h404, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h404,      32'h11111111, 1});
        tv.push_back(vec_t'{32'h800, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'h800, 1, 32'hAAAA5555, 0, 0, 1, 32'h800,      1, 32'h0,        32'h0,        0});
        tv.push_back(vec_t'{32'hFFFFFFFC, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h804,      32'hAAAA5555, 1});
        tv.push_back(vec_t'{32'hFFFFFFFC, 1, 32'h0BADC0DE, 0, 0, 1, 32'hFFFFFFFC, 1, 32'h804, 32'h0,       0});
        tv.push_back(vec_t'{32'h0,   1, 32'h12345678, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0BADC0DE, 1});
        tv.push_back(vec_t'{32'h0,   0, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0,        32'h0,        0});

        do_reset();
        #1;
        chk("reset.req", {31'b0, imem_req_o}, 0);
        chk("reset.pcw", {31'b0, pc_write_o}, 0);
        chk("reset.err", {31'b0, err_o}, 0);
        foreach (tv[k]) begin
            drive(tv[k].pc, tv[k].ack, tv[k].data, tv[k].stall, tv[k].flush);
            #1;
            chk($sformatf("v%0d.req", k), {31'b0, imem_req_o}, {31'b0, tv[k].req});
            if (tv[k].req) chk($sformatf("v%0d.addr", k), imem_addr_o, tv[k].addr);
            chk($sformatf("v%0d.pcw", k), {31'b0, pc_write_o}, {31'b0, tv[k].pcw});
            chk($sformatf("v%0d.pc4", k), ifid_pc4_o, tv[k].pc4);
            chk($sformatf("v%0d.instr", k), ifid_instr_o, tv[k].instr);
            chk($sformatf("v%0d.valid", k), {31'b0, ifid_valid_o}, {31'b0, tv[k].valid});
            @(negedge clk_i);
        end

        // Timeout: 16 unanswered WAIT cycles set err_o, which survives a later ack.
        do_reset();
        drive(32'h300, 0, 0, 0, 0);
        repeat (16) @(negedge clk_i);
        chk("to.err15", {31'b0, err_o}, 0);
        @(negedge clk_i);
        chk("to.err16", {31'b0, err_o}, 1);
        chk("to.req", {31'b0, imem_req_o}, 1);
        drive(32'h300, 1, 32'hCAFEF00D, 0, 0);
        #1;
        chk("to.pcw", {31'b0, pc_write_o}, 1);
        @(negedge clk_i);
        drive(32'h304, 0, 0, 0, 0);
        chk("to.err_after_ack", {31'b0, err_o}, 1);
        chk("to.instr", ifid_instr_o, 32'hCAFEF00D);
        @(negedge clk_i);
        #1;
        chk("to.req2", {31'b0, imem_req_o}, 1);
        rst_i = 1'b0;
        #1;
        chk("arst.req", {31'b0, imem_req_o}, 0);
        chk("arst.pcw", {31'b0, pc_write_o}, 0);
        chk("arst.valid", {31'b0, ifid_valid_o}, 0);
        chk("arst.instr", ifid_instr_o, 0);
        chk("arst.pc4", ifid_pc4_o, 0);
        chk("arst.err", {31'b0, err_o}, 0);

        // Random traffic against the transaction model.
        do_reset();
        m_out = 0; m_drop = 0; m_have = 0; m_err = 0; m_v = 0;
        m_addr = 0; m_word = 0; m_pc4 = 0; m_instr = 0; m_miss = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc, data;
            logic ack, stall, flush;
            int ackp;
            chk("rnd.valid", {31'b0, ifid_valid_o}, {31'b0, m_v});
            chk("rnd.instr", ifid_instr_o, m_instr);
            chk("rnd.pc4", ifid_pc4_o, m_pc4);
            chk("rnd.err", {31'b0, err_o}, {31'b0, m_err});
            ackp = ((c / 200) % 3 == 2) ? 3 : 40;
            pc = $urandom & 32'hFFFFFFFC;
            data = $urandom;
            ack = ($urandom_range(99) < ackp);
            stall = ($urandom_range(99) < 25);
            flush = ($urandom_range(99) < 10);
            drive(pc, ack, data, stall, flush);
            #1;
            chk("rnd.req", {31'b0, imem_req_o}, {31'b0, m_out && !m_drop});
            if (m_out && !m_drop) chk("rnd.addr", imem_addr_o, m_addr);
            chk("rnd.pcw", {31'b0, pc_write_o},
                {31'b0, flush || (!stall && ((m_out && !m_drop && ack) || m_have))});
            model_step(pc, ack, data, stall, flush);
            @(negedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
